light_zone_scheduler: RTL and testbench

- Shares a limited lighting power budget among N independent zones. Each zone has a debounced presence/button request.
- Grants at most MAX_ON zones lit at once, using round-robin arbitration.
- Holds each lit zone for a minimum on-time, then auto-shuts it down after a no-presence hold time.
- Sits between per-zone controller outputs and the LED drivers in the multi-room build.

---
 rtl/light_zone_scheduler.sv | 155 +++++++++++++++
 tb/tb_light_zone_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/light_zone_scheduler.sv
// Round-robin lighting budget scheduler with min-on and hold timers per zone.
// Optional LZS_ZONE0_PRIORITY_EN: zone 0 is granted ahead of the round robin.
module light_zone_scheduler #(
  parameter int N_ZONES  = 4,
  parameter int MAX_ON   = 2,
  parameter int MIN_ON_T = 5000,
  parameter int HOLD_T   = 30000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_ZONES-1:0]         req,
  input  logic                       all_off,
  output logic [N_ZONES-1:0]         zone_on,
  output logic [N_ZONES-1:0]         waiting,
  output logic [$clog2(N_ZONES+1)-1:0] active_cnt
);

  localparam int AW   = $clog2(N_ZONES + 1);
  localparam int PW   = $clog2(N_ZONES);
  localparam int TMAX = (MIN_ON_T > HOLD_T) ? MIN_ON_T : HOLD_T;
  localparam int CW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] MIN_LD  = CW'(MIN_ON_T - 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_T - 1);
  localparam logic [AW-1:0] MAX_CNT = AW'(MAX_ON);

  typedef enum logic {
    Z_OFF = 1'b0,
    Z_ON  = 1'b1
  } zone_state_t;

  zone_state_t        st_q   [N_ZONES];
  zone_state_t        st_d   [N_ZONES];
  logic [CW-1:0]      min_q  [N_ZONES];
  logic [CW-1:0]      min_d  [N_ZONES];
  logic [CW-1:0]      hold_q [N_ZONES];
  logic [CW-1:0]      hold_d [N_ZONES];
  logic [PW-1:0]      ptr_q;
  logic [PW-1:0]      ptr_d;
  logic [N_ZONES-1:0] cand;
  logic [N_ZONES-1:0] grant;
  logic [N_ZONES-1:0] on_d;
  logic [N_ZONES-1:0] waiting_d;
  logic [AW-1:0]      cnt_d;
  logic               budget_free;
  logic               found;

  // Budget check uses the pre-edge count, so a slot freed now is grantable next edge.
  always_comb begin
    cand = '0;
    for (int i = 0; i < N_ZONES; i++) begin
      cand[i] = (st_q[i] == Z_OFF) && req[i];
    end
    budget_free = (active_cnt < MAX_CNT) && !all_off;
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
`ifdef LZS_ZONE0_PRIORITY_EN
    if (budget_free && cand[0]) begin
      grant[0] = 1'b1;
      found    = 1'b1;
    end
`endif
    for (int k = 0; k < N_ZONES; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % N_ZONES;
      if (budget_free && !found && cand[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        ptr_d      = PW'((idx + 1) % N_ZONES);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_ZONES; i++) begin
      st_d[i]   = st_q[i];
      min_d[i]  = min_q[i];
      hold_d[i] = hold_q[i];
      if (all_off) begin
        st_d[i]   = Z_OFF;
        min_d[i]  = '0;
        hold_d[i] = '0;
      end else begin
        unique case (st_q[i])
          Z_OFF: begin
            if (grant[i]) begin
              st_d[i]   = Z_ON;
              min_d[i]  = MIN_LD;
              hold_d[i] = HOLD_LD;
            end
          end
          Z_ON: begin
            if (min_q[i] != '0) begin
              min_d[i] = min_q[i] - 1'b1;
            end
            if (req[i]) begin
              hold_d[i] = HOLD_LD;
            end else if (hold_q[i] != '0) begin
              hold_d[i] = hold_q[i] - 1'b1;
            end
            if (!req[i] && hold_q[i] == '0 && min_q[i] == '0) begin
              st_d[i]   = Z_OFF;
              min_d[i]  = '0;
              hold_d[i] = '0;
            end
          end
          default: begin
            st_d[i] = Z_OFF;
          end
        endcase
      end
    end
  end

  always_comb begin
    on_d  = '0;
    cnt_d = '0;
    for (int i = 0; i < N_ZONES; i++) begin
      on_d[i] = (st_d[i] == Z_ON);
      cnt_d   = cnt_d + AW'(on_d[i]);
    end
    waiting_d = req & ~on_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_ZONES; i++) begin
        st_q[i]   <= Z_OFF;
        min_q[i]  <= '0;
        hold_q[i] <= '0;
      end
      ptr_q      <= '0;
      waiting    <= '0;
      active_cnt <= '0;
    end else begin
      for (int i = 0; i < N_ZONES; i++) begin
        st_q[i]   <= st_d[i];
        min_q[i]  <= min_d[i];
        hold_q[i] <= hold_d[i];
      end
      ptr_q      <= ptr_d;
      waiting    <= waiting_d;
      active_cnt <= cnt_d;
    end
  end

  always_comb begin
    zone_on = '0;
    for (int i = 0; i < N_ZONES; i++) begin
      zone_on[i] = (st_q[i] == Z_ON);
    end
  end

endmodule

// File: tb/tb_light_zone_scheduler.sv
// Bench for light_zone_scheduler: directed scenarios plus random traffic
// against a time-stamp based model of grants, hold and min-on rules.
module tb_light_zone_scheduler;

  localparam int N    = 4;
  localparam int MAXO = 2;
  localparam int MINT = 4;
  localparam int HOLD = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic         all_off;
  logic [N-1:0] zone_on;
  logic [N-1:0] waiting;
  logic [2:0]   active_cnt;

  int checks;
  int errors;
  int cyc;

  bit m_on    [N];
  int m_grant [N];
  int m_last  [N];
  int m_ptr;

  light_zone_scheduler #(
    .N_ZONES (N),
    .MAX_ON  (MAXO),
    .MIN_ON_T(MINT),
    .HOLD_T  (HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .all_off   (all_off),
    .zone_on   (zone_on),
    .waiting   (waiting),
    .active_cnt(active_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_on[i]    = 1'b0;
      m_grant[i] = 0;
      m_last[i]  = 0;
    end
    m_ptr = 0;
  endtask

  function automatic logic [N-1:0] m_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_on[i];
    return v;
  endfunction

  function automatic int m_count();
    int n;
    n = 0;
    for (int i = 0; i < N; i++) n += int'(m_on[i]);
    return n;
  endfunction

  // One clock edge of the scheduling rules, using pre-edge lit set.
  task automatic model_edge(input logic [N-1:0] r, input logic off);
    bit nxt [N];
    int g;
    cyc++;
    if (off) begin
      for (int i = 0; i < N; i++) m_on[i] = 1'b0;
      return;
    end
    for (int i = 0; i < N; i++) begin
      nxt[i] = m_on[i];
      if (m_on[i]) begin
        if (r[i]) m_last[i] = cyc;
        else if (cyc - m_last[i] >= HOLD && cyc - m_grant[i] >= MINT)
          nxt[i] = 1'b0;
      end
    end
    if (m_count() < MAXO) begin
      g = -1;
`ifdef LZS_ZONE0_PRIORITY_EN
      if (!m_on[0] && r[0]) g = 0;
`endif
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (g < 0 && !m_on[idx] && r[idx]) begin
          g = idx;
          m_ptr = (idx + 1) % N;
        end
      end
      if (g >= 0) begin
        nxt[g]     = 1'b1;
        m_grant[g] = cyc;
        m_last[g]  = cyc;
      end
    end
    for (int i = 0; i < N; i++) m_on[i] = nxt[i];
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".zone_on"}, 32'(zone_on), 32'(m_vec()));
    check({tag, ".waiting"}, 32'(waiting), 32'(req & ~m_vec()));
    check({tag, ".cnt"}, 32'(active_cnt), 32'(m_count()));
    check({tag, ".cnt_le_max"}, 32'(active_cnt <= 3'(MAXO)), 32'd1);
  endtask

  task automatic step(input logic [N-1:0] r, input logic off,
                      input string tag);
    @(negedge clk);
    req     = r;
    all_off = off;
    @(posedge clk);
    model_edge(r, off);
    #1;
    compare_all(tag);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check({tag, ".zone_on"}, 32'(zone_on), 32'd0);
    check({tag, ".waiting"}, 32'(waiting), 32'd0);
    check({tag, ".cnt"}, 32'(active_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    req = '0;
    all_off = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    req     = '0;
    all_off = 1'b0;
    rst     = 1'b0;
    model_reset();

    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst.zone_on", 32'(zone_on), 32'd0);
      check("rst.waiting", 32'(waiting), 32'd0);
      check("rst.cnt", 32'(active_cnt), 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) step(4'b0000, 1'b0, "idle");

    step(4'b0001, 1'b0, "single");
    check("single.first", 32'(zone_on), 32'h1);
    repeat (7) step(4'b0000, 1'b0, "single");
    check("single.k7", 32'(zone_on), 32'h1);
    step(4'b0000, 1'b0, "single");
    check("single.k8", 32'(zone_on), 32'h0);

    step(4'b0001, 1'b0, "regrant");
    repeat (4) step(4'b0000, 1'b0, "regrant");
    step(4'b0001, 1'b0, "reraise");
    for (int i = 0; i < 7; i++) begin
      step(4'b0000, 1'b0, "reraise");
      check("reraise.on", 32'(zone_on[0]), 32'd1);
    end
    async_reset("midreset");

    step(4'b1111, 1'b0, "rr");
    check("rr.first", 32'(zone_on), 32'h1);
    step(4'b1111, 1'b0, "rr");
    check("rr.on", 32'(zone_on), 32'h3);
    check("rr.wait", 32'(waiting), 32'hc);
    check("rr.cnt", 32'(active_cnt), 32'd2);
    repeat (3) step(4'b1111, 1'b0, "rr");
    repeat (12) step(4'b1100, 1'b0, "rr_rel");
    check("rr.rel_on", 32'(zone_on), 32'hc);
    repeat (10) step(4'b0000, 1'b0, "drain");

    repeat (3) step(4'b0011, 1'b0, "simul");
    for (int i = 0; i < 8; i++) step(4'b0110, 1'b0, "simul");
    check("simul.k", 32'(zone_on), 32'h2);
    step(4'b0110, 1'b0, "simul");
    check("simul.k1", 32'(zone_on), 32'h6);

    step(4'b0110, 1'b1, "alloff");
    check("alloff.on", 32'(zone_on), 32'h0);
    check("alloff.wait", 32'(waiting), 32'h6);
    step(4'b0110, 1'b1, "alloff");
    repeat (3) step(4'b0110, 1'b0, "resume");

    async_reset("prio_rst");
    step(4'b0011, 1'b0, "prio_setup");
    step(4'b0011, 1'b0, "prio_setup");
    step(4'b0000, 1'b1, "prio_setup");
    step(4'b0101, 1'b0, "prio");
`ifdef LZS_ZONE0_PRIORITY_EN
    check("prio.first", 32'(zone_on), 32'h1);
`else
    check("prio.first", 32'(zone_on), 32'h4);
`endif
    repeat (3) step(4'b0101, 1'b0, "prio");

    for (int t = 0; t < 2500; t++) begin
      logic [N-1:0] r;
      logic o;
      r = 4'($urandom);
      if ($urandom_range(0, 3) == 0) r = '0;
      o = ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 400) == 0) async_reset("rand_rst");
      else step(r, o, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%0d exp=done", cyc);
    $fatal(1);
  end

endmodule
